dmem_responder: RTL and testbench



---
 rtl/dmem_responder.sv | 125 ++++++++++++
 tb/tb_dmem_responder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory slave for the MIPS core: word RAM, status/cycle-counter registers,
// and a write-trace FIFO that records every accepted store for the bench to drain.
module dmem_responder #(
   parameter int unsigned RAM_WORDS   = 64,
   parameter int unsigned TRACE_DEPTH = 8,
   parameter logic [31:0] IO_BASE     = 32'hFFFF_FF00
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           memwrite,
   input  logic [31:0]                    dataadr,
   input  logic [31:0]                    writedata,
   output logic [31:0]                    readdata,
   output logic                           done,
   output logic                           pass,
   output logic                           err_misaligned,
   output logic                           trace_valid,
   output logic [31:0]                    trace_addr,
   output logic [31:0]                    trace_data,
   input  logic                           trace_pop,
   output logic [$clog2(TRACE_DEPTH):0]   trace_count,
   output logic                           trace_overflow
);
   localparam int unsigned AW = $clog2(RAM_WORDS);
   localparam int unsigned PW = $clog2(TRACE_DEPTH);
   localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
   localparam logic [31:0] CYC_ADDR  = IO_BASE + 32'd4;
   localparam logic [PW:0] FULL_CNT  = (PW + 1)'(TRACE_DEPTH);

   logic [31:0]   mem_q     [RAM_WORDS];
   logic [31:0]   tr_addr_q [TRACE_DEPTH];
   logic [31:0]   tr_data_q [TRACE_DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]   cnt_q, cnt_d;
   logic          done_q, done_d, pass_q, pass_d;
   logic          err_q, err_d, ovf_q, ovf_d;
   logic [31:0]   cyc_q, cyc_d;

   logic          ram_hit, status_hit, cycle_hit, store_ok, full, push, pop;
   logic [AW-1:0] word_idx;

   always_comb begin
      ram_hit    = dataadr < RAM_BYTES;
      status_hit = dataadr == IO_BASE;
      cycle_hit  = dataadr == CYC_ADDR;
      word_idx   = dataadr[AW+1:2];
      store_ok   = memwrite && (dataadr[1:0] == 2'b00);
      full       = cnt_q == FULL_CNT;
      pop        = trace_pop && (cnt_q != '0);
      // A full FIFO still accepts a push when the head leaves on the same edge.
      push       = store_ok && (!full || pop);
   end

   always_comb begin
      readdata = 32'h0;
      if (ram_hit)         readdata = mem_q[word_idx];
      else if (status_hit) readdata = {30'b0, pass_q, done_q};
      else if (cycle_hit)  readdata = cyc_q;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      done_d   = done_q;
      pass_d   = pass_q;
      err_d    = err_q;
      ovf_d    = ovf_q;
      cyc_d    = cyc_q;

      if (memwrite && (dataadr[1:0] != 2'b00)) err_d = 1'b1;
      if (store_ok && status_hit && !done_q) begin
         done_d = 1'b1;
         pass_d = writedata == 32'h1;
      end
      if (store_ok && !push) ovf_d = 1'b1;
      if (!done_q && (cyc_q != 32'hFFFF_FFFF)) cyc_d = cyc_q + 32'd1;

      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      cnt_d = cnt_q + 1'b1;
      else if (pop && !push) cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         err_q    <= 1'b0;
         ovf_q    <= 1'b0;
         cyc_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
         err_q    <= err_d;
         ovf_q    <= ovf_d;
         cyc_q    <= cyc_d;
      end
   end

   // Storage arrays carry no reset; only pointers and flags define their validity.
   always_ff @(posedge clk) begin
      if (store_ok && ram_hit) mem_q[word_idx] <= writedata;
      if (push) begin
         tr_addr_q[wr_ptr_q] <= dataadr;
         tr_data_q[wr_ptr_q] <= writedata;
      end
   end

   assign done           = done_q;
   assign pass           = pass_q;
   assign err_misaligned = err_q;
   assign trace_overflow = ovf_q;
   assign trace_count    = cnt_q;
   assign trace_valid    = cnt_q != '0;
   assign trace_addr     = tr_addr_q[rd_ptr_q];
   assign trace_data     = tr_data_q[rd_ptr_q];
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a behavioural model predicts every output,
// and a negedge monitor checks each popped trace entry against the expected queue.
module tb_dmem_responder;
   localparam int unsigned RW = 64;
   localparam int unsigned TD = 8;
   localparam logic [31:0] IO = 32'hFFFF_FF00;
   localparam logic [31:0] RAM_BYTES = 32'(RW * 4);

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        memwrite = 1'b0;
   logic [31:0] dataadr = '0;
   logic [31:0] writedata = '0;
   logic        trace_pop = 1'b0;
   logic [31:0] readdata, trace_addr, trace_data;
   logic        done, pass, err_misaligned, trace_valid, trace_overflow;
   logic [3:0]  trace_count;

   dmem_responder #(.RAM_WORDS(RW), .TRACE_DEPTH(TD), .IO_BASE(IO)) dut (
      .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
      .writedata(writedata), .readdata(readdata), .done(done), .pass(pass),
      .err_misaligned(err_misaligned), .trace_valid(trace_valid),
      .trace_addr(trace_addr), .trace_data(trace_data), .trace_pop(trace_pop),
      .trace_count(trace_count), .trace_overflow(trace_overflow)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_mem [int];
   logic [63:0] exp_q [$];
   int          m_cnt = 0;
   logic        m_done = 0, m_pass = 0, m_err = 0, m_ovf = 0;
   logic [31:0] m_cyc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Trace scoreboard: every head the bench consumes must match the oldest expected store.
   always @(negedge clk) begin
      if (!reset && trace_valid && trace_pop) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL trace_unexpected actual=%h/%h required=none", trace_addr, trace_data);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            chk("trace_addr", trace_addr, e[63:32]);
            chk("trace_data", trace_data, e[31:0]);
         end
      end
   end

   task automatic check_outputs();
      logic [31:0] e;
      bit known;
      known = 1;
      e = '0;
      if (dataadr < RAM_BYTES) begin
         if (m_mem.exists(int'(dataadr[7:2]))) e = m_mem[int'(dataadr[7:2])];
         else known = 0;
      end else if (dataadr == IO)          e = {30'b0, m_pass, m_done};
      else if (dataadr == IO + 32'd4)      e = m_cyc;
      if (known) chk("readdata", readdata, e);
      chk("trace_count", 32'(trace_count), 32'(m_cnt));
      chk("trace_valid", 32'(trace_valid), 32'(m_cnt != 0));
      chk("done", 32'(done), 32'(m_done));
      chk("pass", 32'(pass), 32'(m_pass));
      chk("err_misaligned", 32'(err_misaligned), 32'(m_err));
      chk("trace_overflow", 32'(trace_overflow), 32'(m_ovf));
   endtask

   task automatic model_edge();
      bit pop_ok, pushed;
      logic old_done;
      old_done = m_done;
      pop_ok = trace_pop && (m_cnt != 0);
      pushed = 0;
      if (memwrite) begin
         if (dataadr[1:0] != 2'b00) m_err = 1;
         else begin
            if (dataadr < RAM_BYTES) m_mem[int'(dataadr[7:2])] = writedata;
            else if (dataadr == IO && !m_done) begin
               m_done = 1;
               m_pass = (writedata == 32'h1);
            end
            if (m_cnt < TD || pop_ok) begin
               exp_q.push_back({dataadr, writedata});
               pushed = 1;
            end else m_ovf = 1;
         end
      end
      if (!old_done && m_cyc != 32'hFFFF_FFFF) m_cyc++;
      m_cnt = m_cnt + int'(pushed) - int'(pop_ok);
   endtask

   task automatic cyc(input logic we, input logic [31:0] a, input logic [31:0] d, input logic p);
      memwrite = we; dataadr = a; writedata = d; trace_pop = p;
      @(negedge clk);
      check_outputs();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #10;
      check_outputs();
      #12 reset = 1'b0;
      @(posedge clk);
      #1;
      m_cyc = 1;

      cyc(1, 84, 7, 0);
      cyc(0, 84, 0, 0);
      chk("first_head_addr", trace_addr, 32'd84);
      chk("first_head_data", trace_data, 32'd7);
      cyc(0, 84, 0, 1);

      cyc(1, 80, 32'h11, 0);
      cyc(1, 84, 32'h22, 0);
      cyc(1, 88, 32'h33, 0);
      for (int i = 0; i < 4; i++) cyc(0, 80, 0, 1);
      cyc(0, 88, 0, 0);

      for (int i = 0; i < 9; i++) cyc(1, 32'(i * 4), 32'hA0 + 32'(i), 0);
      chk("full_head_addr", trace_addr, 32'd0);
      cyc(1, 100, 32'hBEEF, 1);
      cyc(0, 100, 0, 0);
      for (int i = 0; i < TD + 2 && m_cnt > 0; i++) cyc(0, 0, 0, 1);

      cyc(1, 86, 5, 0);
      cyc(0, 84, 0, 0);
      cyc(0, 32'h4000, 0, 0);

      for (int i = 0; i < 1500; i++) begin
         int sel;
         logic [31:0] a;
         sel = int'($urandom_range(0, 9));
         if (sel <= 5)      a = {24'h0, 6'($urandom_range(0, RW - 1)), 2'b00};
         else if (sel == 6) a = {24'h0, 6'($urandom_range(0, RW - 1)), 2'($urandom_range(1, 3))};
         else if (sel == 7) a = 32'h1000 + {22'h0, 8'($urandom_range(0, 255)), 2'b00};
         else if (sel == 8) a = IO + 32'd4;
         else               a = {24'h0, 6'($urandom_range(0, RW - 1)), 2'b00};
         cyc(logic'(sel != 9 && $urandom_range(0, 3) != 0), a, $urandom,
             logic'($urandom_range(0, 2) != 0));
      end
      for (int i = 0; i < TD + 2 && m_cnt > 0; i++) cyc(0, IO + 32'd4, 0, 1);
      cyc(0, IO + 32'd4, 0, 0);
      chk("drained", 32'(exp_q.size()), 32'd0);

      cyc(1, IO, 32'h1, 0);
      cyc(0, IO, 0, 0);
      chk("status_word", readdata, 32'h3);
      cyc(0, IO + 32'd4, 0, 0);
      cyc(0, IO + 32'd4, 0, 0);
      cyc(1, IO, 32'h0, 0);
      cyc(0, IO, 0, 0);
      cyc(1, 4, 32'h44, 0);
      cyc(1, 8, 32'h88, 0);

      memwrite = 0; dataadr = IO + 32'd4; trace_pop = 0;
      #2 reset = 1'b1;
      #1;
      chk("rst_trace_valid", 32'(trace_valid), 32'd0);
      chk("rst_trace_count", 32'(trace_count), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_pass", 32'(pass), 32'd0);
      chk("rst_cycle", readdata, 32'd0);
      m_cnt = 0; m_done = 0; m_pass = 0; m_err = 0; m_ovf = 0; m_cyc = 0;
      exp_q.delete();
      @(posedge clk);
      #2 reset = 1'b0;

      cyc(1, 12, 32'h12, 0);
      cyc(0, 12, 0, 1);
      cyc(0, IO + 32'd4, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
